// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {pc, instr} buffer between fetch and decode, flushable on redirect
// Optional predecode of control-transfer opcodes: define FETCH_QUEUE_PREDECODE_EN.
module fetch_queue #(
  parameter int              DEPTH     = 4,
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_valid,
  input  logic [XLEN-1:0]          wr_pc,
  input  logic [XLEN-1:0]          wr_instr,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_instr,
  output logic                     rd_is_ctrl,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic full, empty, push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = wr_valid & ~full & ~flush;
  assign pop   = ~empty & rd_ready & ~flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: it is only visible while count says it is occupied.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[tail_q]    <= wr_pc;
      instr_mem[tail_q] <= wr_instr;
    end
  end

`ifdef FETCH_QUEUE_PREDECODE_EN
  logic ctrl_mem [DEPTH];
  logic wr_is_ctrl;

  // Branch, JAL and JALR opcodes.
  always_comb begin
    wr_is_ctrl = 1'b0;
    case (wr_instr[6:0])
      7'b1100011, 7'b1101111, 7'b1100111: wr_is_ctrl = 1'b1;
      default:                            wr_is_ctrl = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) ctrl_mem[tail_q] <= wr_is_ctrl;
  end

  assign rd_is_ctrl = empty ? 1'b0 : ctrl_mem[head_q];
`else
  assign rd_is_ctrl = 1'b0;
`endif

  assign wr_ready = ~full;
  assign rd_valid = ~empty;
  assign rd_pc    = empty ? '0 : pc_mem[head_q];
  assign rd_instr = empty ? NOP_INSTR : instr_mem[head_q];
  assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (DEPTH=4, XLEN=32)
module tb_fetch_queue;

  localparam int XLEN = 32;
`ifdef FETCH_QUEUE_PREDECODE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            ctrl;
  } entry_t;

  logic            clock = 1'b0;
  logic            reset_n, flush, wr_valid, rd_ready;
  logic [XLEN-1:0] wr_pc, wr_instr;
  logic            wr_ready, rd_valid, rd_is_ctrl;
  logic [XLEN-1:0] rd_pc, rd_instr;
  logic [2:0]      count;

  entry_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  fetch_queue #(.DEPTH(4), .XLEN(XLEN), .NOP_INSTR(32'h00000013)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_pc      (wr_pc),
    .wr_instr   (wr_instr),
    .wr_ready   (wr_ready),
    .rd_valid   (rd_valid),
    .rd_pc      (rd_pc),
    .rd_instr   (rd_instr),
    .rd_is_ctrl (rd_is_ctrl),
    .rd_ready   (rd_ready),
    .count      (count)
  );

  always #5 clock = ~clock;

  // Monitor: every handshake the DUT will take at the next edge is checked against the scoreboard.
  always @(negedge clock) begin
    if (reset_n && rd_valid && rd_ready && !flush) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, required no entry", rd_pc, rd_instr);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        if (rd_pc !== e.pc || rd_instr !== e.instr || rd_is_ctrl !== e.ctrl) begin
          n_bad++;
          $display("FAIL pop_data: got pc=%h instr=%h ctrl=%b, required pc=%h instr=%h ctrl=%b",
                   rd_pc, rd_instr, rd_is_ctrl, e.pc, e.instr, e.ctrl);
        end
      end
    end
  end

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr,
                      input bit ctrl, input bit accepted);
    wr_valid = 1'b1;
    wr_pc    = pc;
    wr_instr = instr;
    if (accepted) exp_q.push_back('{pc: pc, instr: instr, ctrl: ctrl & PRE});
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    flush    = 1'b0;
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    wr_pc    = 32'hdead_beef;
    wr_instr = 32'h1234_5678;
    step();
    step();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_rd_instr", rd_instr,      32'h00000013);
    check("rst_rd_pc",    rd_pc,         32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_is_ctrl",  32'(rd_is_ctrl), 32'd0);

    // first push accepted on the first edge after release
    reset_n  = 1'b1;
    push(32'h0, 32'h00500093, 1'b0, 1'b1);
    check("first_rd_valid", 32'(rd_valid), 32'd1);
    check("first_rd_pc",    rd_pc,         32'h0);
    check("first_rd_instr", rd_instr,      32'h00500093);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("first_drained", 32'(count), 32'd0);

    // fill to full, reject a fifth push, drain in order
    for (int i = 0; i < 4; i++) push(32'(4 * i), 32'h00000093 | 32'(i << 20), 1'b0, 1'b1);
    check("fill_count",    32'(count),    32'd4);
    check("fill_wr_ready", 32'(wr_ready), 32'd0);
    push(32'd16, 32'h00f00093, 1'b0, 1'b0);
    check("overfill_count", 32'(count), 32'd4);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("drain_count",    32'(count),    32'd0);
    check("drain_rd_valid", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    // steady state push+pop at count=2; tail wraps three times over this phase
    push(32'h200, 32'h00100113, 1'b0, 1'b1);
    push(32'h204, 32'h00200113, 1'b0, 1'b1);
    check("conc_pre_count", 32'(count), 32'd2);
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(32'h208 + 32'(4 * i), 32'h00300113 + 32'(i << 20), 1'b0, 1'b1);
      check("conc_count", 32'(count), 32'd2);
    end
    step();
    step();
    check("conc_drained", 32'(count), 32'd0);
    rd_ready = 1'b0;

    // flush with simultaneous write and read
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(4 * i), 32'h00000213, 1'b0, 1'b1);
    check("flush_pre_count", 32'(count), 32'd3);
    flush    = 1'b1;
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_pc    = 32'h3ff;
    wr_instr = 32'h00000313;
    step();
    exp_q.delete();
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check("flush_count",    32'(count),    32'd0);
    check("flush_rd_valid", 32'(rd_valid), 32'd0);
    push(32'h100, 32'h00000393, 1'b0, 1'b1);
    check("post_flush_pc",    rd_pc,         32'h100);
    check("post_flush_count", 32'(count),    32'd1);
    rd_ready = 1'b1;
    step();

    // reads while empty do nothing
    for (int i = 0; i < 3; i++) begin
      step();
      check("empty_count",    32'(count), 32'd0);
      check("empty_rd_instr", rd_instr,   32'h00000013);
    end
    rd_ready = 1'b0;

    // predecode: beq then nop
    push(32'h400, 32'h00000063, 1'b1, 1'b1);
    push(32'h404, 32'h00000013, 1'b0, 1'b1);
    check("pre_head_ctrl", 32'(rd_is_ctrl), 32'(PRE));
    rd_ready = 1'b1;
    step();
    check("pre_second_ctrl", 32'(rd_is_ctrl), 32'd0);
    step();
    rd_ready = 1'b0;

    // asynchronous reset mid-operation discards contents
    push(32'h500, 32'h00000413, 1'b0, 1'b1);
    push(32'h504, 32'h00000493, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count",    32'(count),    32'd0);
    check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    exp_q.delete();
    step();
    reset_n = 1'b1;
    step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
